// File: rtl/iref_pwr_seq_if.sv
// ----------------------------------------------------------------------------
// iref_pwr_seq_if
// Groups the enable/status lines between the power manager, the IREF bias
// cell and the iref_pwr_seq sequencer.
//   EN        : request IREF powered and calibrated (level)
//   RDY_IREF  : asynchronous ready from the IREF cell
//   PU_IREF   : power-up control to the IREF cell
//   CAL_IREF  : calibrate control to the IREF cell
//   IREF_OK   : IREF calibrated and ready
//   IREF_ERR  : sequence failed, sticky until EN=0
//   STATE     : current sequencer state (debug)
//   RETRY_CNT : calibration retries consumed in the current sequence
// master = environment side (drives EN / RDY_IREF), slave = sequencer.
// ----------------------------------------------------------------------------
interface iref_pwr_seq_if;
   logic       EN;
   logic       RDY_IREF;
   logic       PU_IREF;
   logic       CAL_IREF;
   logic       IREF_OK;
   logic       IREF_ERR;
   logic [2:0] STATE;
   logic [1:0] RETRY_CNT;

   modport master (
      output EN, RDY_IREF,
      input  PU_IREF, CAL_IREF, IREF_OK, IREF_ERR, STATE, RETRY_CNT
   );

   modport slave (
      input  EN, RDY_IREF,
      output PU_IREF, CAL_IREF, IREF_OK, IREF_ERR, STATE, RETRY_CNT
   );
endinterface

// File: rtl/iref_pwr_seq.sv
// ----------------------------------------------------------------------------
// iref_pwr_seq
// Power-up sequencer for the IREF bias-current cell: power-up, settle,
// calibrate and ready phases with calibration timeout, bounded retry (with a
// power-off backoff between attempts) and sticky error reporting.
// Ports:
//   CLK : system clock, all logic on the rising edge
//   RST : synchronous active-high reset
//   bus : iref_pwr_seq_if.slave (EN, RDY_IREF in; PU_IREF, CAL_IREF,
//         IREF_OK, IREF_ERR, STATE, RETRY_CNT out)
// All outputs are registered and change on the same edge as the state.
// ----------------------------------------------------------------------------
module iref_pwr_seq #(
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 1024,
   parameter int MAX_RETRY   = 2,
   parameter int CNT_W       = 12
) (
   input  logic          CLK,
   input  logic          RST,
   iref_pwr_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETTLE  = 3'd1,
      CAL     = 3'd2,
      READY   = 3'd3,
      BACKOFF = 3'd4,
      ERROR   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRY);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       retry_q;
   logic             rdy_p0;
   logic             rdy_p1;
   logic             pu_q;
   logic             cal_q;
   logic             ok_q;
   logic             err_q;

   // Output pattern {PU, CAL, OK, ERR} owned by each state. CAL is only ever
   // set in a state that also sets PU, and PU is already high in SETTLE, so
   // the two controls never rise together.
   function automatic logic [3:0] outs_of(state_t s);
      case (s)
         SETTLE:  outs_of = 4'b1000;
         CAL:     outs_of = 4'b1100;
         READY:   outs_of = 4'b1010;
         ERROR:   outs_of = 4'b0001;
         default: outs_of = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         retry_q <= '0;
         rdy_p0  <= 1'b0;
         rdy_p1  <= 1'b0;
         {pu_q, cal_q, ok_q, err_q} <= 4'b0000;
      end else begin
         // ---- stage p0 -> p1: RDY_IREF synchroniser ----
         rdy_p0 <= bus.RDY_IREF;
         rdy_p1 <= rdy_p0;

         // ---- sequencer state, counter and registered outputs ----
         if (!bus.EN) begin
            // Dropping EN aborts from anywhere and clears the retry budget,
            // so the next request always starts a fresh sequence.
            state_q <= IDLE;
            cnt_q   <= '0;
            retry_q <= '0;
            {pu_q, cal_q, ok_q, err_q} <= outs_of(IDLE);
         end else begin
            case (state_q)
               IDLE: begin
                  state_q <= SETTLE;
                  cnt_q   <= '0;
                  {pu_q, cal_q, ok_q, err_q} <= outs_of(SETTLE);
               end
               SETTLE: begin
                  if (cnt_q == SETTLE_LAST) begin
                     state_q <= CAL;
                     cnt_q   <= '0;
                     {pu_q, cal_q, ok_q, err_q} <= outs_of(CAL);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               CAL: begin
                  // A ready that lands on the timeout edge still wins.
                  if (rdy_p1) begin
                     state_q <= READY;
                     cnt_q   <= '0;
                     {pu_q, cal_q, ok_q, err_q} <= outs_of(READY);
                  end else if (cnt_q == TIMEOUT_LAST) begin
                     cnt_q <= '0;
                     if (retry_q < RETRY_MAX) begin
                        retry_q <= retry_q + 2'd1;
                        state_q <= BACKOFF;
                        {pu_q, cal_q, ok_q, err_q} <= outs_of(BACKOFF);
                     end else begin
                        state_q <= ERROR;
                        {pu_q, cal_q, ok_q, err_q} <= outs_of(ERROR);
                     end
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               BACKOFF: begin
                  // Cell is unpowered here so it drops RDY_IREF; any ready
                  // seen now is stale and deliberately ignored.
                  if (cnt_q == SETTLE_LAST) begin
                     state_q <= SETTLE;
                     cnt_q   <= '0;
                     {pu_q, cal_q, ok_q, err_q} <= outs_of(SETTLE);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               READY: begin
                  // Losing ready after calibration is a hard failure.
                  if (!rdy_p1) begin
                     state_q <= ERROR;
                     {pu_q, cal_q, ok_q, err_q} <= outs_of(ERROR);
                  end
               end
               ERROR: begin
                  state_q <= ERROR;
               end
               default: begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  retry_q <= '0;
                  {pu_q, cal_q, ok_q, err_q} <= outs_of(IDLE);
               end
            endcase
         end
      end
   end

   assign bus.PU_IREF   = pu_q;
   assign bus.CAL_IREF  = cal_q;
   assign bus.IREF_OK   = ok_q;
   assign bus.IREF_ERR  = err_q;
   assign bus.STATE     = state_q;
   assign bus.RETRY_CNT = retry_q;

endmodule

// File: tb/tb_iref_pwr_seq.sv
// ----------------------------------------------------------------------------
// tb_iref_pwr_seq
// Directed bench for iref_pwr_seq with SETTLE_CYC=4, TIMEOUT_CYC=20,
// MAX_RETRY=1. A table of {inputs, edge count, expected outputs} records is
// applied in order; each record holds its inputs for n rising edges and then
// compares all outputs. Hand-written sequences follow for the ready/timeout
// race and for ready being ignored during backoff. Edge numbers in the
// comments count from the edge where EN is first sampled high (edge 0).
// ----------------------------------------------------------------------------
module tb_iref_pwr_seq;

   localparam int SETTLE = 4;
   localparam int TMO    = 20;
   localparam int MR     = 1;

   localparam bit [3:0] O_IDLE = 4'b0000;
   localparam bit [3:0] O_SET  = 4'b1000;
   localparam bit [3:0] O_CAL  = 4'b1100;
   localparam bit [3:0] O_RDY  = 4'b1010;
   localparam bit [3:0] O_BO   = 4'b0000;
   localparam bit [3:0] O_ERR  = 4'b0001;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   iref_pwr_seq_if ifc ();

   iref_pwr_seq #(
      .SETTLE_CYC (SETTLE),
      .TIMEOUT_CYC(TMO),
      .MAX_RETRY  (MR),
      .CNT_W      (12)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(ifc)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string    name;
      bit       rst;
      bit       en;
      bit       rdy;
      int       n;
      bit [3:0] outs;
      bit [2:0] st;
      bit [1:0] rc;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string name, bit rst, bit en, bit rdy, int n,
                               bit [3:0] outs, bit [2:0] st, bit [1:0] rc);
      vec_t v;
      v.name = name; v.rst = rst; v.en = en; v.rdy = rdy; v.n = n;
      v.outs = outs; v.st = st; v.rc = rc;
      vecs.push_back(v);
   endfunction

   task automatic drive(bit rst, bit en, bit rdy);
      RST          = rst;
      ifc.EN       = en;
      ifc.RDY_IREF = rdy;
   endtask

   // One rising edge, then sample 1 time unit later. CAL without PU is never
   // legal, so that is checked on every edge.
   task automatic step();
      @(posedge CLK);
      #1;
      checks++;
      if (ifc.CAL_IREF === 1'b1 && ifc.PU_IREF !== 1'b1) begin
         errors++;
         $display("FAIL cal_implies_pu: CAL_IREF=%b PU_IREF=%b at t=%0t",
                  ifc.CAL_IREF, ifc.PU_IREF, $time);
      end
   endtask

   task automatic check(string name, bit [3:0] outs, bit [2:0] st, bit [1:0] rc);
      logic [8:0] act;
      logic [8:0] exp;
      act = {ifc.PU_IREF, ifc.CAL_IREF, ifc.IREF_OK, ifc.IREF_ERR, ifc.STATE, ifc.RETRY_CNT};
      exp = {outs, st, rc};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got pu/cal/ok/err=%b state=%0d retry=%0d, expected pu/cal/ok/err=%b state=%0d retry=%0d (t=%0t)",
                  name, act[8:5], act[4:2], act[1:0], exp[8:5], exp[4:2], exp[1:0], $time);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b1, 1'b0, 1'b0);

      //   name                 rst en rdy  n  outs    st rc
      add("reset",               1, 0, 0,  2, O_IDLE, 0, 0);
      add("rst_beats_en",        1, 1, 0,  1, O_IDLE, 0, 0);
      add("idle_hold",           0, 0, 0,  2, O_IDLE, 0, 0);
      // Nominal power-up: PU at 0, CAL at 4, RDY at 14, READY at 16
      add("t1_settle",           0, 1, 0,  1, O_SET,  1, 0);
      add("t1_settle_hold",      0, 1, 0,  3, O_SET,  1, 0);
      add("t1_cal_rise",         0, 1, 0,  1, O_CAL,  2, 0);
      add("t1_cal_wait",         0, 1, 0,  9, O_CAL,  2, 0);
      add("t1_rdy_sync",         0, 1, 1,  2, O_CAL,  2, 0);
      add("t1_ready",            0, 1, 1,  1, O_RDY,  3, 0);
      add("t1_ready_hold",       0, 1, 1,  5, O_RDY,  3, 0);
      // Ready lost in READY: ERROR two edges after RDY first sampled low
      add("t4_rdy_lost_sync",    0, 1, 0,  2, O_RDY,  3, 0);
      add("t4_error",            0, 1, 0,  1, O_ERR,  5, 0);
      add("t4_error_sticky",     0, 1, 1,  3, O_ERR,  5, 0);
      add("t4_en_low_idle",      0, 0, 0,  1, O_IDLE, 0, 0);
      // RDY never comes: timeout 24, backoff 24-27, settle 28, CAL 32, ERROR 52
      add("t2_settle",           0, 1, 0,  1, O_SET,  1, 0);
      add("t2_cal",              0, 1, 0,  4, O_CAL,  2, 0);
      add("t2_cal_wait",         0, 1, 0, 19, O_CAL,  2, 0);
      add("t2_backoff",          0, 1, 0,  1, O_BO,   4, 1);
      add("t2_backoff_hold",     0, 1, 0,  3, O_BO,   4, 1);
      add("t2_resettle",         0, 1, 0,  1, O_SET,  1, 1);
      add("t2_cal2",             0, 1, 0,  4, O_CAL,  2, 1);
      add("t2_cal2_wait",        0, 1, 0, 19, O_CAL,  2, 1);
      add("t2_error",            0, 1, 0,  1, O_ERR,  5, 1);
      add("t2_error_hold",       0, 1, 0,  2, O_ERR,  5, 1);
      add("t2_en_low",           0, 0, 0,  1, O_IDLE, 0, 0);
      // Retry succeeds: RDY at 42 in second CAL, READY at 44 with retry=1
      add("t3_settle",           0, 1, 0,  1, O_SET,  1, 0);
      add("t3_cal",              0, 1, 0, 23, O_CAL,  2, 0);
      add("t3_backoff",          0, 1, 0,  1, O_BO,   4, 1);
      add("t3_resettle",         0, 1, 0,  4, O_SET,  1, 1);
      add("t3_cal2",             0, 1, 0, 13, O_CAL,  2, 1);
      add("t3_rdy_sync",         0, 1, 1,  2, O_CAL,  2, 1);
      add("t3_ready",            0, 1, 1,  1, O_RDY,  3, 1);
      add("t3_ready_hold",       0, 1, 1,  2, O_RDY,  3, 1);
      add("t3_en_low",           0, 0, 0,  1, O_IDLE, 0, 0);
      // EN drop clears retry; EN drop mid-CAL at edge 8; fresh sequence after
      add("t5_settle",           0, 1, 0,  1, O_SET,  1, 0);
      add("t5_to_backoff",       0, 1, 0, 23, O_CAL,  2, 0);
      add("t5_backoff",          0, 1, 0,  1, O_BO,   4, 1);
      add("t5_en_low",           0, 0, 0,  1, O_IDLE, 0, 0);
      add("t5b_settle",          0, 1, 0,  1, O_SET,  1, 0);
      add("t5b_cal",             0, 1, 0,  4, O_CAL,  2, 0);
      add("t5b_cal_mid",         0, 1, 0,  3, O_CAL,  2, 0);
      add("t5b_en_drop",         0, 0, 0,  1, O_IDLE, 0, 0);
      add("t5c_settle",          0, 1, 0,  1, O_SET,  1, 0);
      add("t5c_cal",             0, 1, 0, 23, O_CAL,  2, 0);
      add("t5c_backoff",         0, 1, 0,  1, O_BO,   4, 1);
      add("t5c_en_low",          0, 0, 0,  1, O_IDLE, 0, 0);
      // RST in SETTLE, and RST rising with EN falling on the same edge
      add("t6_settle",           0, 1, 0,  2, O_SET,  1, 0);
      add("t6_rst_mid",          1, 1, 0,  1, O_IDLE, 0, 0);
      add("t6_rst_hold_en",      1, 1, 0,  1, O_IDLE, 0, 0);
      add("t6_release",          0, 1, 0,  1, O_SET,  1, 0);
      add("t6_rst_en_toggle",    1, 0, 0,  1, O_IDLE, 0, 0);
      add("t6_idle",             0, 0, 0,  1, O_IDLE, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].en, vecs[i].rdy);
         repeat (vecs[i].n) step();
         check(vecs[i].name, vecs[i].outs, vecs[i].st, vecs[i].rc);
      end

      // Ready and timeout on the same edge: RDY sampled at 22, synced ready
      // seen at 24 together with the timeout count; READY must win.
      drive(1'b0, 1'b1, 1'b0);
      repeat (5) step();                       // edges 0-4
      check("h1_cal_entered", O_CAL, 3'd2, 2'd0);
      repeat (17) step();                      // edges 5-21
      drive(1'b0, 1'b1, 1'b1);
      repeat (2) step();                       // edges 22-23
      check("h1_cal_before_race", O_CAL, 3'd2, 2'd0);
      step();                                  // edge 24
      check("h1_ready_beats_timeout", O_RDY, 3'd3, 2'd0);
      drive(1'b0, 1'b0, 1'b0);
      step();
      check("h1_en_low", O_IDLE, 3'd0, 2'd0);

      // Ready during BACKOFF must not shorten or exit it; the still-high
      // ready is then taken on the first CAL edge after entry (edge 33).
      drive(1'b0, 1'b1, 1'b0);
      repeat (25) step();                      // edges 0-24
      check("h2_backoff", O_BO, 3'd4, 2'd1);
      drive(1'b0, 1'b1, 1'b1);
      for (int k = 25; k <= 27; k++) begin
         step();
         check($sformatf("h2_backoff_ignores_rdy_e%0d", k), O_BO, 3'd4, 2'd1);
      end
      step();                                  // edge 28
      check("h2_resettle", O_SET, 3'd1, 2'd1);
      repeat (4) step();                       // edges 29-32
      check("h2_cal2_entry", O_CAL, 3'd2, 2'd1);
      step();                                  // edge 33
      check("h2_ready_after_backoff", O_RDY, 3'd3, 2'd1);
      drive(1'b0, 1'b0, 1'b0);
      step();
      check("h2_en_low", O_IDLE, 3'd0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/iref_pwr_seq.md
Name: iref_pwr_seq

Overview:
- Power-up sequencer that sits directly upstream of the IREF bias-current cell.
- Drives the cell's PU_IREF and CAL_IREF controls and consumes its RDY_IREF status.
- Runs power-up, settle, calibrate and ready phases, with timeout, bounded retry and error reporting.
- Exposes one enable input and OK/ERR status to the top-level power manager.

Parameters:
SETTLE_CYC, 16, cycles PU_IREF is held before CAL_IREF asserts; also the BACKOFF length (>=1)
TIMEOUT_CYC, 1024, max cycles in CAL waiting for synced RDY_IREF (>=1)
MAX_RETRY, 2, calibration retries allowed before ERROR (0..3)
CNT_W, 12, phase counter width; must hold max(SETTLE_CYC,TIMEOUT_CYC)-1

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  reset, synchronous, active-high
EN  in  1  request IREF powered and calibrated; level-sensitive
RDY_IREF  in  1  ready from IREF cell; passed through a 2-flop synchroniser (rdy_s)
PU_IREF  out  1  power-up control to IREF cell
CAL_IREF  out  1  calibrate control to IREF cell
IREF_OK  out  1  IREF calibrated and ready
IREF_ERR  out  1  sequence failed; sticky until EN=0
STATE  out  3  current state encoding, for debug
RETRY_CNT  out  2  retries consumed in the current sequence

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, counter=0, retry=0, both sync flops=0. All outputs 0, STATE=0.
- Outputs are registered. They update on the same edge the state changes.
- States, with encodings and outputs (PU, CAL, OK, ERR):
  - IDLE=0: 0000
  - SETTLE=1: 1000
  - CAL=2: 1100
  - READY=3: 1010
  - BACKOFF=4: 0000
  - ERROR=5: 0001
- Priority at each edge: RST, then EN=0, then state transitions.
  - EN=0 in any state: go to IDLE next edge, clear retry and counter.
- IDLE: EN=1 -> SETTLE, counter=0.
- SETTLE: counter increments each edge.
  - At counter==SETTLE_CYC-1: go to CAL, counter=0.
  - Net effect: SETTLE entered at edge k, CAL_IREF rises at edge k+SETTLE_CYC.
- CAL: counter increments.
  - rdy_s=1 -> READY. This has priority over timeout when both occur on the same edge.
  - Counter==TIMEOUT_CYC-1 with rdy_s=0 -> timeout:
    - retry<MAX_RETRY: retry++, go to BACKOFF, counter=0.
    - otherwise: go to ERROR.
- Synchroniser latency: RDY_IREF first sampled high at edge m -> rdy_s=1 after edge m+1 -> READY and IREF_OK=1 at edge m+2.
- BACKOFF: PU_IREF=0 so the IREF cell clears RDY_IREF.
  - Held for SETTLE_CYC edges, then go to SETTLE, counter=0.
  - rdy_s is ignored in BACKOFF.
- READY: CAL_IREF deasserted, PU_IREF held.
  - rdy_s falling to 0 while EN=1 -> ERROR. Loss of ready is not retried.
- ERROR: stays until EN=0, then IDLE. An EN re-assert in the same cycle is not seen; EN must be low for at least one edge.
- retry saturates at MAX_RETRY and never wraps. RETRY_CNT holds its value in READY and ERROR.
- RST asserted mid-sequence: outputs 0 on that edge; PU_IREF and CAL_IREF drop immediately.
- PU_IREF and CAL_IREF are never both 0->1 on the same edge. CAL_IREF=1 implies PU_IREF=1.

Test Plan (SETTLE_CYC=4, TIMEOUT_CYC=20, MAX_RETRY=1, IREF model returns RDY 10 cycles after CAL):
1. Reset, then EN=1 at edge 0:
   - PU_IREF=1 at edge 0, CAL_IREF=1 at edge 4.
   - RDY_IREF high at edge 14 -> IREF_OK=1, CAL_IREF=0 at edge 16.
   - STATE=3, RETRY_CNT=0.
2. RDY_IREF held 0:
   - Timeout at edge 24 -> BACKOFF (PU=0) edges 24-27, SETTLE at 28, CAL at 32.
   - Second timeout at edge 52 -> ERROR, IREF_ERR=1, RETRY_CNT=1.
3. First CAL times out, RDY returns during the second CAL -> READY with RETRY_CNT=1, IREF_ERR=0.
4. In READY, force RDY_IREF=0 -> ERROR 2 edges later, PU_IREF=0. Then EN=0 for one cycle -> IDLE, all outputs 0.
5. EN drops mid-CAL at edge 8 -> IDLE at edge 8, PU/CAL=0. EN re-asserted -> fresh sequence, RETRY_CNT=0.
6. RST=1 during SETTLE, and RST and EN toggled on the same edge -> all outputs 0 next edge; RST wins.
